// File: rtl/ppu_oam_arbiter.sv
// Sprite RAM (OAM) owner: arbitrates eval reads, $4014 DMA and $2003/$2004 CPU access.
// Build option: define OAM_ATTR_MASK_EN to clear attribute bits 4:2 on writes to addr[1:0]==2.
module ppu_oam_arbiter #(
  parameter int EVAL_COL = 257,
  parameter int VIS_ROWS = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  curr_row,
  input  logic [8:0]  curr_col,
  input  logic        rendering_en,
  output logic        eval_start,
  input  logic        eval_busy,
  input  logic [7:0]  eval_addr,
  output logic [7:0]  eval_data,
  output logic [7:0]  oam_addr,
  input  logic        cpu_oamaddr_we,
  input  logic        cpu_oamdata_we,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  output logic        dma_bus_req,
  output logic [15:0] dma_bus_addr,
  input  logic        dma_bus_ack,
  input  logic [7:0]  dma_bus_data,
  output logic        dma_busy,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  localparam logic [8:0] LP_EVAL_COL = 9'(EVAL_COL);
  localparam logic [9:0] LP_VIS_ROWS = 10'(VIS_ROWS);

  typedef enum logic [1:0] {DMA_IDLE, DMA_REQ, DMA_WRITE} dma_state_t;

  dma_state_t  r_dma_state;
  logic [7:0]  r_dma_page;
  logic [8:0]  r_dma_cnt;
  logic [7:0]  r_dma_base;
  logic [7:0]  r_dma_data;
  logic        r_dma_busy;
  logic        r_dma_req;

  logic [7:0]  r_oam_addr;
  logic        r_eval_busy_d;
  logic        r_col_hit_d;
  logic        r_eval_start;
  logic        r_pend_valid;
  logic [7:0]  r_pend_addr;
  logic [7:0]  r_pend_data;
  logic        r_idle_d;
  logic [7:0]  r_cpu_rdata;

  logic        w_render_win;
  logic        w_col_hit;
  logic        w_cpu_accept;
  logic        w_busy_fall;
  logic        w_grant_dma;
  logic        w_grant_cpu;
  logic        w_grant_idle;
  logic [8:0]  w_dma_cnt_inc;
  logic [7:0]  w_dma_waddr;
  logic [7:0]  w_ram_addr;
  logic [7:0]  w_raw_wdata;
  logic        w_ram_we;

  assign w_render_win  = rendering_en && !curr_row[8] && ({1'b0, curr_row} < LP_VIS_ROWS);
  assign w_col_hit     = (curr_col == LP_EVAL_COL);
  assign w_cpu_accept  = cpu_oamdata_we && !w_render_win && !r_dma_busy;
  assign w_busy_fall   = r_eval_busy_d && !eval_busy && w_render_win;
  assign w_dma_cnt_inc = r_dma_cnt + 9'd1;
  assign w_dma_waddr   = r_dma_base + r_dma_cnt[7:0];

  // Fixed priority: eval > DMA write > pending CPU write > idle read at OAMADDR
  assign w_grant_dma  = !eval_busy && (r_dma_state == DMA_WRITE);
  assign w_grant_cpu  = !eval_busy && (r_dma_state != DMA_WRITE) && r_pend_valid;
  assign w_grant_idle = !eval_busy && (r_dma_state != DMA_WRITE) && !r_pend_valid;

  always_comb begin
    w_ram_addr  = r_oam_addr;
    w_raw_wdata = 8'h00;
    w_ram_we    = 1'b0;
    if (eval_busy) begin
      w_ram_addr = eval_addr;
    end else if (w_grant_dma) begin
      w_ram_addr  = w_dma_waddr;
      w_raw_wdata = r_dma_data;
      w_ram_we    = 1'b1;
    end else if (w_grant_cpu) begin
      w_ram_addr  = r_pend_addr;
      w_raw_wdata = r_pend_data;
      w_ram_we    = 1'b1;
    end
  end

`ifdef OAM_ATTR_MASK_EN
  assign ram_wdata = (w_ram_addr[1:0] == 2'd2) ? (w_raw_wdata & 8'hE3) : w_raw_wdata;
`else
  assign ram_wdata = w_raw_wdata;
`endif

  assign ram_addr     = w_ram_addr;
  assign ram_we       = w_ram_we;
  assign eval_data    = ram_rdata;
  assign eval_start   = r_eval_start;
  assign oam_addr     = r_oam_addr;
  assign cpu_rdata    = r_cpu_rdata;
  assign dma_busy     = r_dma_busy;
  assign dma_bus_req  = r_dma_req;
  assign dma_bus_addr = {r_dma_page, r_dma_cnt[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eval_busy_d <= 1'b0;
      r_col_hit_d   <= 1'b0;
      r_eval_start  <= 1'b0;
      r_oam_addr    <= 8'h00;
    end else begin
      r_eval_busy_d <= eval_busy;
      r_col_hit_d   <= w_col_hit;
      r_eval_start  <= w_render_win && w_col_hit && !r_col_hit_d && !eval_busy;
      if (cpu_oamaddr_we)
        r_oam_addr <= cpu_wdata;
      else if (w_busy_fall)
        r_oam_addr <= 8'h00;
      else if (w_cpu_accept)
        r_oam_addr <= r_oam_addr + 8'd1;
    end
  end

  // A newer accepted write replaces an uncommitted one, address included
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 8'h00;
      r_pend_data  <= 8'h00;
      r_idle_d     <= 1'b0;
      r_cpu_rdata  <= 8'h00;
    end else begin
      if (w_cpu_accept) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= r_oam_addr;
        r_pend_data  <= cpu_wdata;
      end else if (w_grant_cpu) begin
        r_pend_valid <= 1'b0;
      end
      r_idle_d <= w_grant_idle;
      if (r_idle_d)
        r_cpu_rdata <= ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dma_state <= DMA_IDLE;
      r_dma_page  <= 8'h00;
      r_dma_cnt   <= 9'd0;
      r_dma_base  <= 8'h00;
      r_dma_data  <= 8'h00;
      r_dma_busy  <= 1'b0;
      r_dma_req   <= 1'b0;
    end else begin
      case (r_dma_state)
        DMA_IDLE: begin
          if (dma_start) begin
            r_dma_page  <= dma_page;
            r_dma_cnt   <= 9'd0;
            r_dma_base  <= r_oam_addr;
            r_dma_busy  <= 1'b1;
            r_dma_req   <= 1'b1;
            r_dma_state <= DMA_REQ;
          end
        end
        DMA_REQ: begin
          if (dma_bus_ack) begin
            r_dma_data  <= dma_bus_data;
            r_dma_req   <= 1'b0;
            r_dma_state <= DMA_WRITE;
          end
        end
        DMA_WRITE: begin
          // Data is held here for as long as eval owns the RAM
          if (w_grant_dma) begin
            r_dma_cnt <= w_dma_cnt_inc;
            if (w_dma_cnt_inc[8]) begin
              r_dma_busy  <= 1'b0;
              r_dma_state <= DMA_IDLE;
            end else begin
              r_dma_req   <= 1'b1;
              r_dma_state <= DMA_REQ;
            end
          end
        end
        default: r_dma_state <= DMA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ppu_oam_arbiter.sv
// Randomized bench for ppu_oam_arbiter: external OAM model, bus responder and a byte-level reference.
// Honours OAM_ATTR_MASK_EN the same way the design build does.
module tb_ppu_oam_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  curr_row = '0;
  logic [8:0]  curr_col = '0;
  logic        rendering_en = 1'b0;
  logic        eval_start;
  logic        eval_busy = 1'b0;
  logic [7:0]  eval_addr = '0;
  logic [7:0]  eval_data;
  logic [7:0]  oam_addr;
  logic        cpu_oamaddr_we = 1'b0;
  logic        cpu_oamdata_we = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        dma_start = 1'b0;
  logic [7:0]  dma_page = '0;
  logic        dma_bus_req;
  logic [15:0] dma_bus_addr;
  logic        dma_bus_ack = 1'b0;
  logic [7:0]  dma_bus_data = '0;
  logic        dma_busy;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = '0;

  logic [7:0]  mem [0:255] = '{default: 8'h00};
  logic [7:0]  exp_mem [0:255];
  logic [7:0]  src [0:255];
  logic [7:0]  exp_oam;
  logic [15:0] acked_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          es_cnt = 0;
  int          grant_seen = 0;
  int          grant_bad = 0;

  ppu_oam_arbiter dut (
    .clk(clk), .rst(rst), .curr_row(curr_row), .curr_col(curr_col),
    .rendering_en(rendering_en), .eval_start(eval_start), .eval_busy(eval_busy),
    .eval_addr(eval_addr), .eval_data(eval_data), .oam_addr(oam_addr),
    .cpu_oamaddr_we(cpu_oamaddr_we), .cpu_oamdata_we(cpu_oamdata_we),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dma_start(dma_start),
    .dma_page(dma_page), .dma_bus_req(dma_bus_req), .dma_bus_addr(dma_bus_addr),
    .dma_bus_ack(dma_bus_ack), .dma_bus_data(dma_bus_data), .dma_busy(dma_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port OAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // CPU bus seen by DMA: acks after a random delay
  always @(negedge clk) begin
    if (dma_bus_req && $urandom_range(0, 2) == 0) begin
      dma_bus_ack  = 1'b1;
      dma_bus_data = src[dma_bus_addr[7:0]];
    end else begin
      dma_bus_ack  = 1'b0;
      dma_bus_data = 8'($urandom);
    end
  end

  always @(posedge clk)
    if (rst && dma_bus_req && dma_bus_ack) acked_q.push_back(dma_bus_addr);

  always @(negedge clk) begin
    if (rst && eval_busy) begin
      grant_seen++;
      if (ram_addr !== eval_addr || ram_we !== 1'b0 || eval_data !== ram_rdata) grant_bad++;
    end
    if (eval_start === 1'b1) es_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] a, input logic [7:0] d);
`ifdef OAM_ATTR_MASK_EN
    return (a[1:0] == 2'd2) ? (d & 8'hE3) : d;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set_addr(input logic [7:0] a);
    cpu_oamaddr_we = 1'b1;
    cpu_wdata = a;
    tick();
    cpu_oamaddr_we = 1'b0;
    exp_oam = a;
  endtask

  // Accepted write: model stores at OAMADDR and advances it
  task automatic cpu_write(input logic [7:0] d);
    cpu_oamdata_we = 1'b1;
    cpu_wdata = d;
    tick();
    cpu_oamdata_we = 1'b0;
    exp_mem[exp_oam] = stored(exp_oam, d);
    exp_oam = exp_oam + 8'd1;
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_val(tag, bad, 0);
  endtask

  task automatic run_dma(input logic [7:0] base, input logic [7:0] page, input bit stall, input bit ramp_src);
    int cyc = 0;
    int bad = 0;
    for (int i = 0; i < 256; i++) src[i] = ramp_src ? 8'(i) : 8'($urandom);
    acked_q.delete();
    cpu_set_addr(base);
    dma_page = page;
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    while (dma_busy === 1'b1 && cyc < 20000) begin
      eval_busy = stall && ((cyc >= 50 && cyc < 60) || $urandom_range(0, 9) == 0);
      eval_addr = 8'($urandom);
      dma_start = (cyc == 30);
      dma_page = page ^ 8'hFF;
      cpu_oamdata_we = (cyc == 40);
      cpu_wdata = 8'h55;
      tick();
      cyc++;
    end
    eval_busy = 1'b0;
    dma_start = 1'b0;
    cpu_oamdata_we = 1'b0;
    check_val("dma_busy_done", dma_busy, 0);
    for (int n = 0; n < 256; n++) exp_mem[8'(base + 8'(n))] = stored(8'(base + 8'(n)), src[n]);
    repeat (3) tick();
    compare_mem("dma_ram");
    check_val("dma_oam_addr", oam_addr, base);
    check_val("dma_ack_count", acked_q.size(), 256);
    for (int n = 0; n < acked_q.size(); n++) if (acked_q[n] !== {page, 8'(n)}) bad++;
    check_val("dma_bus_addr_seq", bad, 0);
    check_val("dma_bus_req_idle", dma_bus_req, 0);
  endtask

  initial begin
    logic [7:0] a, d;
    int nw, es0, k;
    logic [8:0] row;
    bit en, pre_busy, win;

    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    exp_oam = 8'h00;
    repeat (3) tick();
    check_val("rst_eval_start", eval_start, 0);
    check_val("rst_dma_busy", dma_busy, 0);
    check_val("rst_dma_bus_req", dma_bus_req, 0);
    check_val("rst_oam_addr", oam_addr, 0);
    check_val("rst_cpu_rdata", cpu_rdata, 0);
    check_val("rst_ram_we", ram_we, 0);
    rst = 1'b1;
    tick();

    cpu_set_addr(8'h10);
    cpu_write(8'hAA);
    cpu_write(8'hBB);
    cpu_write(8'hCC);
    repeat (4) tick();
    check_val("cpu_oam_addr_13", oam_addr, 8'h13);
    check_val("cpu_ram_10", mem[8'h10], stored(8'h10, 8'hAA));
    check_val("cpu_ram_12", mem[8'h12], stored(8'h12, 8'hCC));
    check_val("cpu_rdata_13", cpu_rdata, exp_mem[8'h13]);

    cpu_set_addr(8'h02);
    cpu_write(8'hFF);
    repeat (3) tick();
`ifdef OAM_ATTR_MASK_EN
    check_val("attr_mask_02", mem[8'h02], 8'hE3);
`else
    check_val("attr_mask_02", mem[8'h02], 8'hFF);
`endif

    for (int t = 0; t < 6; t++) begin
      a = 8'($urandom);
      nw = $urandom_range(1, 8);
      cpu_set_addr(a);
      for (int j = 0; j < nw; j++) begin
        d = 8'($urandom);
        cpu_write(d);
        repeat ($urandom_range(0, 2)) tick();
      end
      repeat (4) tick();
      check_val("cpu_rand_oam_addr", oam_addr, exp_oam);
      compare_mem("cpu_rand_ram");
      cpu_set_addr(a);
      repeat (4) tick();
      check_val("cpu_rdata_readback", cpu_rdata, exp_mem[a]);
      check_val("cpu_read_no_inc", oam_addr, a);
    end

    run_dma(8'h04, 8'h02, 1'b0, 1'b1);
    run_dma(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    run_dma(8'($urandom), 8'($urandom), 1'b1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      cpu_set_addr(8'($urandom));
      case ($urandom_range(0, 3))
        0: row = 9'($urandom_range(0, 239));
        1: row = 9'($urandom_range(239, 255));
        2: row = 9'($urandom_range(256, 511));
        default: row = (t % 2 == 0) ? 9'd0 : 9'd239;
      endcase
      en = ($urandom_range(0, 3) != 0);
      pre_busy = ($urandom_range(0, 3) == 0);
      win = en && (row < 9'd240);
      rendering_en = en;
      curr_row = row;
      eval_busy = pre_busy;
      eval_addr = 8'($urandom);
      es0 = es_cnt;
      for (int c = 250; c <= 260; c++) begin
        curr_col = 9'(c);
        cpu_oamdata_we = (c == 252);
        cpu_wdata = 8'h55;
        if (c == 252 && !win) begin
          exp_mem[exp_oam] = stored(exp_oam, 8'h55);
          exp_oam = exp_oam + 8'd1;
        end
        k = (c == 257) ? $urandom_range(1, 4) : 1;
        repeat (k) begin
          tick();
          cpu_oamdata_we = 1'b0;
        end
      end
      check_val("eval_start_pulses", es_cnt - es0, (win && !pre_busy) ? 1 : 0);
      check_val("eval_oam_addr_hold", oam_addr, exp_oam);
      eval_busy = 1'b1;
      repeat ($urandom_range(5, 15)) begin
        eval_addr = 8'($urandom);
        tick();
      end
      eval_busy = 1'b0;
      if (win) exp_oam = 8'h00;
      repeat (4) tick();
      check_val("eval_oam_addr_after", oam_addr, exp_oam);
      compare_mem("eval_ram");
      rendering_en = 1'b0;
      curr_row = '0;
      curr_col = '0;
      tick();
    end

    for (int i = 0; i < 256; i++) src[i] = 8'($urandom);
    acked_q.delete();
    cpu_set_addr(8'h30);
    dma_page = 8'($urandom);
    dma_start = 1'b1;
    tick();
    dma_start = 1'b0;
    repeat (100) tick();
    #2;
    rst = 1'b0;
    tick();
    check_val("rst_mid_dma_busy", dma_busy, 0);
    check_val("rst_mid_dma_req", dma_bus_req, 0);
    check_val("rst_mid_oam_addr", oam_addr, 0);
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    compare_mem("rst_ram_untouched");

    check_val("eval_grant_seen", grant_seen > 50, 1);
    check_val("eval_grant_bad", grant_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
